// File: rtl/mul_pkg.sv
// Shared definitions for the sequential Booth multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_pkg;

    localparam int MUL_WIDTH = 16;
    localparam int MUL_STEPS = 16;
    // One extra bit so the counter can hold MUL_STEPS itself without wrapping.
    localparam int MUL_CNT_W = $clog2(MUL_STEPS) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_booth_step.sv
// One radix-2 Booth recoding step: add/subtract Mreg per {Qreg[0], q_m1}, then
// arithmetic right shift of {A, Qreg, q_m1}.
// Latency: combinational. Backpressure: none.
// Ports: acc/qreg/q_m1 = current partial state, mreg = sign-extended multiplicand,
//        *_nxt = state after this step.
module mul_booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] qreg,
    input  logic             q_m1,
    input  logic [WIDTH:0]   mreg,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] qreg_nxt,
    output logic             q_m1_nxt
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case ({qreg[0], q_m1})
            2'b01:   sum = acc + mreg;
            2'b10:   sum = acc - mreg;
            default: sum = acc;
        endcase
        // Shift the combined {sum, qreg, q_m1} right by one, replicating the sign.
        acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
        qreg_nxt = {sum[0], qreg[WIDTH-1:1]};
        q_m1_nxt = qreg[0];
    end

endmodule

// File: rtl/mul_16.sv
// Sequential signed WIDTHxWIDTH multiplier (radix-2 Booth, one step per clock).
// Latency: start accepted at T0, done/product valid in the cycle after T17; one op per 18 cycles.
// Backpressure: start is ignored while busy; no queueing, caller waits for done.
// Ports: clk, reset_n (async, active-low), start, multiplicand, multiplier (sampled with start),
//        product (held until next FINISH), busy, done (single-cycle pulse).
module mul_16
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam logic [MUL_CNT_W-1:0] LAST_STEP = MUL_CNT_W'(WIDTH - 1);

    mul_state_t             state_q, state_d;
    logic [WIDTH:0]         acc_q, acc_d;
    logic [WIDTH:0]         mreg_q, mreg_d;
    logic [WIDTH-1:0]       qreg_q, qreg_d;
    logic                   q_m1_q, q_m1_d;
    logic [MUL_CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0]     product_d;
    logic                   busy_d;
    logic                   done_d;

    logic [WIDTH:0]         step_acc;
    logic [WIDTH-1:0]       step_qreg;
    logic                   step_q_m1;

    mul_booth_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .acc      (acc_q),
        .qreg     (qreg_q),
        .q_m1     (q_m1_q),
        .mreg     (mreg_q),
        .acc_nxt  (step_acc),
        .qreg_nxt (step_qreg),
        .q_m1_nxt (step_q_m1)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mreg_q  <= '0;
            qreg_q  <= '0;
            q_m1_q  <= 1'b0;
            count_q <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mreg_q  <= mreg_d;
            qreg_q  <= qreg_d;
            q_m1_q  <= q_m1_d;
            count_q <= count_d;
            product <= product_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mreg_d    = mreg_q;
        qreg_d    = qreg_q;
        q_m1_d    = q_m1_q;
        count_d   = count_q;
        product_d = product;
        busy_d    = busy;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // busy drops here unless a new op is accepted in the same cycle,
                // which keeps it high continuously for back-to-back starts.
                busy_d = start;
                if (start) begin
                    state_d = CALC;
                    acc_d   = '0;
                    mreg_d  = {multiplicand[WIDTH-1], multiplicand};
                    qreg_d  = multiplier;
                    q_m1_d  = 1'b0;
                    count_d = '0;
                end
            end
            CALC: begin
                busy_d  = 1'b1;
                acc_d   = step_acc;
                qreg_d  = step_qreg;
                q_m1_d  = step_q_m1;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                busy_d    = 1'b1;
                // The 33-bit {A, Qreg} always fits in 32 bits; A[WIDTH] is a redundant sign.
                product_d = {acc_q[WIDTH-1:0], qreg_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_16.sv
// Self-checking bench for mul_16: vector table, hand-written corner sequences,
// and a randomized sweep, all results checked through an expected-value queue.
module tb_mul_16;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [31:0] product;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic        done_prev = 1'b0;

    typedef struct {
        logic [15:0] m;
        logic [15:0] q;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    mul_16 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] m, input logic [15:0] q);
        logic signed [15:0] sm;
        logic signed [15:0] sq;
        logic signed [31:0] p;
        sm = m;
        sq = q;
        p  = sm * sq;
        return p;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            check("done_single_cycle", {31'd0, done_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got product %h with no operation pending", product);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
        done_prev <= done;
    end

    // Counts negedges until done (inclusive); bcnt counts busy cycles before done.
    task automatic wait_done(output int n, output int bcnt);
        n    = 0;
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
            if (busy) bcnt++;
        end
        if (n == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no done within 40 cycles, required done");
        end
    endtask

    task automatic run_op(input logic [15:0] m, input logic [15:0] q,
                          input logic [31:0] exp, input bit chk_timing);
        int n;
        int b;
        @(posedge clk);
        #1;
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        wait_done(n, b);
        if (chk_timing) begin
            check("latency", 32'(n), 32'd18);
            check("busy_cycles", 32'(b), 32'd17);
            check("busy_at_done", {31'd0, busy}, 32'd1);
            @(negedge clk);
            check("busy_after_done", {31'd0, busy}, 32'd0);
            check("done_after_done", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int          n;
        int          b;
        int          dcnt;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [15:0] rm;
        logic [15:0] rq;
        logic [15:0] extremes[5];

        vecs[0] = '{16'd3,     16'd5,     32'h0000_000F};
        vecs[1] = '{16'hFFF9,  16'd6,     32'hFFFF_FFD6};
        vecs[2] = '{16'd0,     16'h1234,  32'h0000_0000};
        vecs[3] = '{16'h8000,  16'h8000,  32'h4000_0000};
        vecs[4] = '{16'h7FFF,  16'h8000,  32'hC000_8000};
        vecs[5] = '{16'd100,   16'hFF9C,  32'hFFFF_D8F0};
        vecs[6] = '{16'hFFFF,  16'hFFFF,  32'h0000_0001};
        vecs[7] = '{16'd1,     16'h8000,  32'hFFFF_8000};
        vecs[8] = '{16'h1234,  16'h1234,  32'h014B_5A90};
        extremes = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001};

        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_product", product, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].m, vecs[i].q, vecs[i].exp, 1'b1);
        end

        // Start re-pulsed at count 5 with new operands: must be ignored.
        e_a = model(16'h04D2, 16'hFDC9);
        @(posedge clk);
        #1;
        start = 1'b1; multiplicand = 16'h04D2; multiplier = 16'hFDC9;
        exp_q.push_back(e_a);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; multiplicand = 16'h7FFF; multiplier = 16'h7FFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, b);
        check("ignored_start_latency", 32'(n), 32'd12);
        repeat (25) @(negedge clk);
        check("ignored_start_hold", product, e_a);
        check("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Reset at count 8: partial result discarded, no done pulse.
        @(posedge clk);
        #1;
        start = 1'b1; multiplicand = 16'd1000; multiplier = 16'hF448;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_product", product, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midreset_no_done", 32'(dcnt), 32'd0);
        run_op(16'd100, 16'hFF9C, 32'hFFFF_D8F0, 1'b1);

        // Start held across two operations.
        e_a = model(16'h0123, 16'hFEDC);
        e_b = model(16'h8001, 16'h0777);
        @(posedge clk);
        #1;
        start = 1'b1; multiplicand = 16'h0123; multiplier = 16'hFEDC;
        exp_q.push_back(e_a);
        @(posedge clk);
        #1;
        multiplicand = 16'h8001; multiplier = 16'h0777;
        exp_q.push_back(e_b);
        wait_done(n, b);
        check("held_first_latency", 32'(n), 32'd18);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, b);
        check("held_done_spacing", 32'(n), 32'd18);
        check("held_busy_continuous", 32'(b), 32'd17);
        @(negedge clk);
        check("held_idle_after", {31'd0, busy}, 32'd0);

        // Randomized sweep, biased toward extreme operands.
        for (int k = 0; k < 2000; k++) begin
            rm = ($urandom_range(0, 7) == 0) ? extremes[$urandom_range(0, 4)] : 16'($urandom);
            rq = ($urandom_range(0, 7) == 0) ? extremes[$urandom_range(0, 4)] : 16'($urandom);
            run_op(rm, rq, model(rm, rq), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
